// File: rtl/fork_2_l_alu.sv
// fork_2_l_alu: opcode-steered dispatch into two per-channel FIFOs.
// Ports: clk, rst (sync, active-high); req_in/instr_in/ack_out upstream;
//   req_out_k/instr_out_k/seq_out_k/ack_in_k per channel (1 = ld/st,
//   2 = R/I-op/NOP); illegal pulse and saturating illegal_cnt.

module fork_2_l_alu_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 35
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end
endmodule

module fork_2_l_alu #(
  parameter int DEPTH = 2,
  parameter int SEQ_W = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_in,
  input  logic [31:0]      instr_in,
  output logic             ack_out,
  output logic             req_out_1,
  output logic [31:0]      instr_out_1,
  output logic [SEQ_W-1:0] seq_out_1,
  input  logic             ack_in_1,
  output logic             req_out_2,
  output logic [31:0]      instr_out_2,
  output logic [SEQ_W-1:0] seq_out_2,
  input  logic             ack_in_2,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);
  localparam int W = 32 + SEQ_W;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_NOP   = 7'b0000000;

  logic [6:0]       opcode;
  logic             is_ch1;
  logic             is_ch2;
  logic             is_ill;
  logic             full_1;
  logic             full_2;
  logic             empty_1;
  logic             empty_2;
  logic             accept;
  logic             push_1;
  logic             push_2;
  logic             pop_1;
  logic             pop_2;
  logic [SEQ_W-1:0] seq;
  logic [W-1:0]     dout_1;
  logic [W-1:0]     dout_2;

  assign opcode = instr_in[6:0];

  always_comb begin
    is_ch1 = 1'b0;
    is_ch2 = 1'b0;
    case (opcode)
      OP_LOAD, OP_STORE:    is_ch1 = 1'b1;
      OP_R, OP_I, OP_NOP:   is_ch2 = 1'b1;
      default:              ;
    endcase
  end

  assign is_ill = !(is_ch1 || is_ch2);

  // Illegal opcodes are always taken (and dropped). Legal ones wait on
  // their own FIFO only; a same-cycle pop does not free a full slot.
  always_comb begin
    ack_out = 1'b0;
    if (!rst) begin
      if (is_ill)      ack_out = 1'b1;
      else if (is_ch1) ack_out = !full_1;
      else             ack_out = !full_2;
    end
  end

  assign accept = req_in && ack_out;
  assign push_1 = accept && is_ch1;
  assign push_2 = accept && is_ch2;
  assign pop_1  = ack_in_1 && !empty_1;
  assign pop_2  = ack_in_2 && !empty_2;

  fork_2_l_alu_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo_1 (
    .clk   (clk),
    .rst   (rst),
    .push  (push_1),
    .pop   (pop_1),
    .din   ({instr_in, seq}),
    .dout  (dout_1),
    .full  (full_1),
    .empty (empty_1)
  );

  fork_2_l_alu_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo_2 (
    .clk   (clk),
    .rst   (rst),
    .push  (push_2),
    .pop   (pop_2),
    .din   ({instr_in, seq}),
    .dout  (dout_2),
    .full  (full_2),
    .empty (empty_2)
  );

  assign req_out_1                = !empty_1;
  assign req_out_2                = !empty_2;
  assign {instr_out_1, seq_out_1} = dout_1;
  assign {instr_out_2, seq_out_2} = dout_2;

  always_ff @(posedge clk) begin
    if (rst) begin
      seq         <= '0;
      illegal     <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      if (push_1 || push_2) seq <= seq + 1'b1;
      illegal <= accept && is_ill;
      if (accept && is_ill && (illegal_cnt != '1))
        illegal_cnt <= illegal_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_fork_2_l_alu.sv
// tb_fork_2_l_alu: randomized + directed scoreboard bench for fork_2_l_alu.
// Reference model tracks per-channel queues, tag, and illegal counter.
module tb_fork_2_l_alu;
  localparam int DEPTH = 2;
  localparam int SEQ_W = 3;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_in;
  logic [31:0]      instr_in;
  logic             ack_out;
  logic             req_out_1;
  logic [31:0]      instr_out_1;
  logic [SEQ_W-1:0] seq_out_1;
  logic             ack_in_1;
  logic             req_out_2;
  logic [31:0]      instr_out_2;
  logic [SEQ_W-1:0] seq_out_2;
  logic             ack_in_2;
  logic             illegal;
  logic [CNT_W-1:0] illegal_cnt;

  fork_2_l_alu #(.DEPTH(DEPTH), .SEQ_W(SEQ_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_in      (req_in),
    .instr_in    (instr_in),
    .ack_out     (ack_out),
    .req_out_1   (req_out_1),
    .instr_out_1 (instr_out_1),
    .seq_out_1   (seq_out_1),
    .ack_in_1    (ack_in_1),
    .req_out_2   (req_out_2),
    .instr_out_2 (instr_out_2),
    .seq_out_2   (seq_out_2),
    .ack_in_2    (ack_in_2),
    .illegal     (illegal),
    .illegal_cnt (illegal_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void chk(bit ok, string nm, longint act, longint exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endfunction

  // Reference model state
  logic [31+SEQ_W:0] exp1[$];
  logic [31+SEQ_W:0] exp2[$];
  int               occ1 = 0;
  int               occ2 = 0;
  logic [SEQ_W-1:0] m_seq = '0;
  bit               m_ill = 0;
  int               m_cnt = 0;
  bit               live = 0;

  function automatic int route(logic [6:0] op);
    if (op == 7'h03 || op == 7'h23) return 1;
    if (op == 7'h33 || op == 7'h13 || op == 7'h00) return 2;
    return 0;
  endfunction

  // Model: compare DUT state against model, then apply the coming edge.
  always @(negedge clk) begin : model
    int  r;
    bit  ea;
    bit  acc;
    r  = route(instr_in[6:0]);
    ea = !rst && ((r == 0) || (r == 1 ? occ1 < DEPTH : occ2 < DEPTH));
    if (live) begin
      chk(ack_out == ea, "ack_out", ack_out, ea);
      chk(req_out_1 == (occ1 != 0), "req_out_1", req_out_1, occ1 != 0);
      chk(req_out_2 == (occ2 != 0), "req_out_2", req_out_2, occ2 != 0);
      chk(illegal == m_ill, "illegal", illegal, m_ill);
      chk(illegal_cnt == m_cnt, "illegal_cnt", illegal_cnt, m_cnt);
    end
    if (rst) begin
      exp1.delete();
      exp2.delete();
      occ1  = 0;
      occ2  = 0;
      m_seq = '0;
      m_ill = 0;
      m_cnt = 0;
      live  = 1;
    end else begin
      acc = req_in && ea;
      if (occ1 > 0 && ack_in_1) occ1--;
      if (occ2 > 0 && ack_in_2) occ2--;
      if (acc && r == 1) begin
        exp1.push_back({instr_in, m_seq});
        occ1++;
        m_seq++;
      end else if (acc && r == 2) begin
        exp2.push_back({instr_in, m_seq});
        occ2++;
        m_seq++;
      end
      m_ill = acc && (r == 0);
      if (m_ill && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end
  end

  // Monitor: pop expected head whenever a channel transfer occurs.
  always @(negedge clk) begin : monitor
    logic [31+SEQ_W:0] e;
    if (rst === 1'b0) begin
      if (req_out_1 && ack_in_1) begin
        if (exp1.size() == 0) chk(0, "ch1_underflow", 1, 0);
        else begin
          e = exp1.pop_front();
          chk({instr_out_1, seq_out_1} == e, "ch1_head",
              {instr_out_1, seq_out_1}, e);
        end
      end
      if (req_out_2 && ack_in_2) begin
        if (exp2.size() == 0) chk(0, "ch2_underflow", 1, 0);
        else begin
          e = exp2.pop_front();
          chk({instr_out_2, seq_out_2} == e, "ch2_head",
              {instr_out_2, seq_out_2}, e);
        end
      end
    end
  end

  task automatic step(input bit r, input bit rq, input logic [31:0] ins,
                      input bit k1, input bit k2);
    rst      = r;
    req_in   = rq;
    instr_in = ins;
    ack_in_1 = k1;
    ack_in_2 = k2;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [6:0]  ops [8];
    logic [31:0] w;
    ops[0] = 7'h03; ops[1] = 7'h23; ops[2] = 7'h33; ops[3] = 7'h13;
    ops[4] = 7'h00; ops[5] = 7'h7F; ops[6] = 7'h6F; ops[7] = 7'h37;
    w = $urandom();
    w[6:0] = ops[$urandom_range(0, 7)];
    return w;
  endfunction

  initial begin
    step(1, 0, 32'h0, 0, 0);
    step(1, 0, 32'h0, 0, 0);
    // load then add, consumers ready
    step(0, 1, 32'h0000_2003, 1, 1);
    step(0, 1, 32'h0000_0033, 1, 1);
    step(0, 0, 32'h0, 1, 1);
    step(0, 0, 32'h0, 1, 1);
    // ch1 stalled: three stores, R-type interleaved
    step(0, 1, 32'h0000_1023, 0, 1);
    step(0, 1, 32'h0000_2023, 0, 1);
    step(0, 1, 32'h0020_80B3, 0, 1);
    step(0, 1, 32'h0000_3023, 0, 1);
    step(0, 0, 32'h0, 0, 1);
    // full ch1 with same-cycle pop: refused, then accepted
    step(0, 1, 32'h0000_4023, 1, 1);
    step(0, 1, 32'h0000_4023, 1, 1);
    step(0, 0, 32'h0, 1, 1);
    step(0, 0, 32'h0, 1, 1);
    // illegal between two legal instructions
    step(0, 1, 32'h0000_0013, 1, 1);
    step(0, 1, 32'h0000_007F, 1, 1);
    step(0, 1, 32'h0000_0003, 1, 1);
    step(0, 0, 32'h0, 1, 1);
    // ten legal instructions: tag wrap
    for (int i = 0; i < 10; i++)
      step(0, 1, {i[24:0], 7'h33}, 1, 1);
    step(0, 0, 32'h0, 1, 1);
    // saturate illegal_cnt
    for (int i = 0; i < 260; i++)
      step(0, 1, 32'hDEAD_007F, 1, 1);
    step(0, 0, 32'h0, 1, 1);
    chk(illegal_cnt == 8'hFF, "illegal_cnt_sat", illegal_cnt, 8'hFF);
    // reset with both FIFOs loaded
    step(0, 1, 32'h0000_5003, 0, 0);
    step(0, 1, 32'h0000_5033, 0, 0);
    step(1, 1, 32'h0000_6033, 1, 1);
    step(0, 1, 32'h0000_7033, 1, 1);
    step(0, 0, 32'h0, 1, 1);
    // randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
           rnd_instr(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 2) != 0);
    // drain
    for (int i = 0; i < 6; i++)
      step(0, 0, 32'h0, 1, 1);
    chk(exp1.size() == 0, "ch1_drained", exp1.size(), 0);
    chk(exp2.size() == 0, "ch2_drained", exp2.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
